// File: rtl/cache_ctrl.sv
// Miss/refill sequencer for one data-cache set.
// Ports: CLK, Reset (sync, high); MemRead/MemWrite/Addr request; Hit/Dirty/OutTag from set;
//        MemReady handshake; Ctls/Stall/MemReq/MemWE/MemAddr drive; Hit/MissCount stats.
module cache_ctrl #(
    parameter int MEM_BEATS = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic        Hit,
    input  logic        Dirty,
    input  logic [25:0] OutTag,
    input  logic        MemReady,
    output logic [6:0]  Ctls,
    output logic        Stall,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL
    } state_t;

    localparam logic [1:0] LAST = 2'(MEM_BEATS - 1);

    state_t     state;
    logic [1:0] cnt;
    logic       req;
    logic       unused_ok;

    assign req       = MemRead | MemWrite;
    assign unused_ok = ^Addr[1:0];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            HitCount  <= 32'd0;
            MissCount <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        if (Hit) begin
                            HitCount <= HitCount + 32'd1;
                        end else begin
                            MissCount <= MissCount + 32'd1;
                            cnt       <= 2'd0;
                            state     <= Dirty ? WB : REFILL;
                        end
                    end
                end
                WB: begin
                    if (MemReady) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST) state <= REFILL;
                    end
                end
                REFILL: begin
                    if (MemReady) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ctls = {wen, setValid, setDirty, offset[1:0], init, offsetSW}
    always_comb begin
        Ctls    = 7'd0;
        Stall   = req & ~((state == IDLE) & Hit);
        MemReq  = 1'b0;
        MemWE   = 1'b0;
        MemAddr = 32'd0;
        unique case (state)
            IDLE: begin
                if (req & Hit) begin
                    if (MemWrite)
                        Ctls = {3'b111, Addr[3:2], 2'b11};
                    else
                        Ctls = {3'b000, Addr[3:2], 2'b10};
                end else if (req) begin
                    // init latches the LRU victim for the whole miss
                    Ctls = 7'b0000010;
                end
            end
            WB: begin
                MemReq  = 1'b1;
                MemWE   = 1'b1;
                MemAddr = {OutTag, Addr[5:4], cnt, 2'b00};
                Ctls    = {3'b000, cnt, 2'b00};
            end
            REFILL: begin
                MemReq  = 1'b1;
                MemAddr = {Addr[31:4], cnt, 2'b00};
                if (MemReady)
                    Ctls = {3'b110, cnt, 2'b00};
                else
                    Ctls = {3'b000, cnt, 2'b00};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl.
// Reference is a per-access queue of expected memory beats.
module tb_cache_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic        Hit;
    logic        Dirty;
    logic [25:0] OutTag;
    logic        MemReady;
    logic [6:0]  Ctls;
    logic        Stall;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] HitCount;
    logic [31:0] MissCount;

    always #5 CLK = ~CLK;

    cache_ctrl #(.MEM_BEATS(4)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .Hit       (Hit),
        .Dirty     (Dirty),
        .OutTag    (OutTag),
        .MemReady  (MemReady),
        .Ctls      (Ctls),
        .Stall     (Stall),
        .MemReq    (MemReq),
        .MemWE     (MemWE),
        .MemAddr   (MemAddr),
        .HitCount  (HitCount),
        .MissCount (MissCount)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] m_hit = 32'd0;
    logic [31:0] m_miss = 32'd0;
    int          rdy_pat[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] hit_ctls(input bit st, input logic [1:0] w);
        if (st) return {3'b111, w, 2'b11};
        return {3'b000, w, 2'b10};
    endfunction

    task automatic chk_counts(input string tag);
        check({tag, "_hits"}, HitCount, m_hit);
        check({tag, "_miss"}, MissCount, m_miss);
    endtask

    task automatic idle_cycle();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Hit      = 1'($urandom);
        MemReady = 1'($urandom);
        Addr     = $urandom;
        @(negedge CLK);
        check("idle_stall", 32'(Stall), 32'd0);
        check("idle_ctls", 32'(Ctls), 32'd0);
        check("idle_req", 32'(MemReq), 32'd0);
        check("idle_addr", MemAddr, 32'd0);
        @(posedge CLK); #1;
        chk_counts("idle");
    endtask

    task automatic do_access(input bit st, input logic [31:0] a, input bit hit,
                             input bit dirty, input logic [25:0] tag);
        logic [31:0] qa[$];
        bit          qw[$];
        int          stalls;
        int          waits;
        int          guard;
        int          nbeats;
        bit          rdy;
        stalls   = 0;
        waits    = 0;
        guard    = 0;
        MemWrite = st;
        MemRead  = st ? 1'($urandom_range(1)) : 1'b1;
        Addr     = a;
        Dirty    = dirty;
        OutTag   = tag;
        Hit      = hit;
        MemReady = 1'($urandom);
        if (!hit) begin
            if (dirty)
                for (int i = 0; i < 4; i++) begin
                    qa.push_back({tag, a[5:4], 2'(i), 2'b00});
                    qw.push_back(1'b1);
                end
            for (int i = 0; i < 4; i++) begin
                qa.push_back({a[31:4], 2'(i), 2'b00});
                qw.push_back(1'b0);
            end
        end
        nbeats = qa.size();
        @(negedge CLK);
        stalls += int'(Stall);
        check("first_ctls", 32'(Ctls), hit ? 32'(hit_ctls(st, a[3:2])) : 32'h2);
        check("first_req", 32'(MemReq), 32'd0);
        @(posedge CLK); #1;
        if (hit) m_hit++;
        else m_miss++;
        chk_counts("first");
        if (!hit) begin
            while (qa.size() > 0 && guard < 200) begin
                guard++;
                if (rdy_pat.size() > 0) rdy = rdy_pat.pop_front() != 0;
                else rdy = $urandom_range(99) < 70;
                MemReady = rdy;
                Hit      = 1'($urandom);
                Dirty    = 1'($urandom);
                @(negedge CLK);
                stalls += int'(Stall);
                check("beat_req", 32'(MemReq), 32'd1);
                check("beat_we", 32'(MemWE), 32'(qw[0]));
                check("beat_addr", MemAddr, qa[0]);
                if (qw[0])
                    check("wb_ctls", 32'(Ctls), 32'({3'b000, qa[0][3:2], 2'b00}));
                else if (rdy)
                    check("rf_ctls", 32'(Ctls), 32'({3'b110, qa[0][3:2], 2'b00}));
                else
                    check("rf_wen", 32'(Ctls[6]), 32'd0);
                @(posedge CLK); #1;
                if (rdy) begin
                    void'(qa.pop_front());
                    void'(qw.pop_front());
                end else begin
                    waits++;
                end
            end
            check("beat_left", qa.size(), 32'd0);
            Hit      = 1'b1;
            MemReady = 1'($urandom);
            @(negedge CLK);
            stalls += int'(Stall);
            check("retry_ctls", 32'(Ctls), 32'(hit_ctls(st, a[3:2])));
            check("retry_req", 32'(MemReq), 32'd0);
            @(posedge CLK); #1;
            m_hit++;
            chk_counts("retry");
        end
        check("stall_cycles", stalls, hit ? 32'd0 : 32'(1 + nbeats + waits));
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Addr     = 32'd0;
        Hit      = 1'b0;
        Dirty    = 1'b0;
        OutTag   = 26'd0;
        MemReady = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        chk_counts("reset");
        idle_cycle();

        do_access(1'b0, 32'h0000_0048, 1'b1, 1'b0, 26'h0);
        do_access(1'b0, 32'h1234_5670, 1'b0, 1'b0, 26'h155);
        do_access(1'b1, 32'h0000_0010, 1'b0, 1'b1, 26'h3);
        rdy_pat = '{1, 0, 0, 1, 0, 1, 1};
        do_access(1'b0, 32'h0ABC_DE40, 1'b0, 1'b0, 26'h7);
        idle_cycle();

        // reset lands while refill is at beat 2
        MemRead  = 1'b1;
        Addr     = 32'h1234_5670;
        Hit      = 1'b0;
        Dirty    = 1'b0;
        MemReady = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_beat2", MemAddr, 32'h1234_5678);
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset   = 1'b0;
        MemRead = 1'b0;
        m_hit   = 32'd0;
        m_miss  = 32'd0;
        @(negedge CLK);
        check("rst_req", 32'(MemReq), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        chk_counts("rst");
        @(posedge CLK); #1;
        do_access(1'b0, 32'h1234_5670, 1'b0, 1'b0, 26'h1);

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(3) == 0) idle_cycle();
            do_access(1'($urandom), $urandom, $urandom_range(2) == 0,
                      1'($urandom), 26'($urandom));
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for one cache set of the pipeline data cache. It watches the MEM-stage load/store request and the set's Hit/Dirty outputs, then drives the set's 7-bit control bundle. On a miss it stalls the pipeline, writes back a dirty victim block word by word, and refills the block from main memory over a req/ready handshake. It also keeps hit/miss statistics counters.

## Interface
Parameters:
- MEM_BEATS, 4, words per block; fixed at 4, since the word counter and `offset` are 2 bits.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `MemRead` in 1: load in MEM stage.
- `MemWrite` in 1: store in MEM stage; wins if both are high.
- `Addr` in 32: access byte address. Tag is [31:6], index is [5:4], word is [3:2].
- `Hit` in 1: set hit, combinational.
- `Dirty` in 1: selected way dirty.
- `OutTag` in 26: tag of the selected way.
- `MemReady` in 1: memory accepts the write word, or presents `MemReadData`, this cycle.
- `Ctls` out 7: {wen, setValid, setDirty, offset[1:0], init, offsetSW} to the set.
- `Stall` out 1: freeze the pipeline.
- `MemReq` out 1: memory request.
- `MemWE` out 1: 1 = write-back beat, 0 = refill beat.
- `MemAddr` out 32: word address for the current beat.
- `HitCount` out 32: completed-hit counter.
- `MissCount` out 32: miss counter.

Memory write data is the set's ReadData, wired outside this block.

## Operation
- States: IDLE, WB, REFILL. The 2-bit beat counter `cnt` counts 0 to 3.
- `req` = MemRead | MemWrite.
- IDLE with `req & Hit`:
  - Load: wen=0, offset=Addr[3:2], init=1.
  - Store: wen=1, setValid=1, setDirty=1, offset=Addr[3:2], offsetSW=1, init=1.
  - HitCount increments.
  - Stall=0.
- IDLE with `req & ~Hit`:
  - Stall=1, init=1, wen=0. The LRU victim is latched; init stays 0 in WB and REFILL so the victim select is frozen.
  - MissCount increments.
  - Next state is WB if Dirty, else REFILL; `cnt` is cleared to 0.
- IDLE with no request: all Ctls 0, Stall=0.
- WB:
  - MemReq=1, MemWE=1, MemAddr={OutTag, Addr[5:4], cnt, 2'b00}.
  - Ctls: offset=cnt, everything else 0.
  - On `MemReady`, `cnt` increments. The beat where `cnt`=3 and `MemReady`=1 goes to REFILL with `cnt`=0.
- REFILL:
  - MemReq=1, MemWE=0, MemAddr={Addr[31:4], cnt, 2'b00}.
  - On `MemReady`: wen=1, setValid=1, setDirty=0, offset=cnt, offsetSW=0 (MemReadData written); `cnt` increments.
  - Without `MemReady`: wen=0.
  - The last beat goes to IDLE.
- After refill the access is re-evaluated in IDLE and now hits. A store completes there, setting dirty; HitCount counts it as well.
- Stall = `req & ~(state==IDLE & Hit)`.
- `req` and `Addr` must stay stable while Stall=1. The pipeline guarantees this.
- Hit is ignored outside IDLE.
- Counters wrap modulo 2^32.
- Address arithmetic is pure concatenation; no adders.

## Timing
- Reset values:
  - state=IDLE, cnt=0.
  - HitCount=0, MissCount=0.
  - MemReq=0, MemWE=0, MemAddr=0 (IDLE drives 0), Ctls=0.
  - Stall=0 when there is no request.
- `Reset` asserted mid-WB or mid-REFILL returns to IDLE on the next edge and MemReq drops. A partial block already written stays valid per the set's state; no memory retry.
- Hit: zero stall cycles; the store write lands on the same edge.
- Clean miss, MemReady always 1:
  - Cycle 0: detect, Stall=1.
  - Cycles 1–4: refill beats.
  - Cycle 5: hit, Stall=0.
  - Total: 5 stall cycles.
- Dirty miss, MemReady always 1: 9 stall cycles (detect, 4 WB, 4 REFILL).
- Each MemReady=0 cycle in WB or REFILL adds one stall cycle. MemAddr and MemReq are held unchanged.
- MemReady outside WB/REFILL is ignored.
- A beat is transferred only on a cycle with MemReq & MemReady.
- Outputs are combinational from state, cnt, Addr and the inputs. Only state, cnt and the counters are registered.

## Test plan
- Reset, then idle:
  - Stimulus: `Reset` high 2 cycles, no request.
  - Required: Ctls=0, MemReq=0, Stall=0, counters 0.
- Load hit to 0x00000048:
  - Stimulus: Hit=1.
  - Required: Stall=0, offset=2'b10, wen=0, init=1, HitCount=1 on the next cycle.
- Clean load miss to 0x12345670:
  - Stimulus: Hit=0, Dirty=0, MemReady=1.
  - Required: MissCount=1; MemAddr sequence 0x12345670, 0x12345674, 0x12345678, 0x1234567C with wen=1 on each beat; Stall high exactly 5 cycles.
- Dirty store miss to 0x00000010:
  - Stimulus: OutTag=0x3, MemReady=1.
  - Required: WB addresses 0xD0, 0xD4, 0xD8, 0xDC with MemWE=1; then refill 0x10 to 0x1C; then a store hit with setDirty=1 and offsetSW=1; Stall high 9 cycles.
- Backpressure:
  - Stimulus: MemReady pattern 1,0,0,1,0,1,1 during a clean refill.
  - Required: cnt advances only on 1s; MemAddr held during 0s; wen only on 1s; Stall high 8 cycles.
- Reset during REFILL:
  - Stimulus: `Reset` asserted at beat 2.
  - Required: next cycle state=IDLE, MemReq=0, counters 0; a fresh miss afterwards starts at beat 0.
